// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, drives a synchronous instruction memory and
// registers the IF/ID output. Supports stall, redirect with flush, and HALT.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] req_pc_r;
    logic        req_vld_r;
    logic        in_fetch_s;
    logic        take_redirect_s;
    logic        advance_s;
    logic        halt_hit_s;

    // Decode the per-edge action in priority order: redirect, stall, advance.
    always_comb begin
        in_fetch_s      = 1'b0;
        take_redirect_s = 1'b0;
        advance_s       = 1'b0;
        halt_hit_s      = 1'b0;
        if (state_r == FETCH) begin
            in_fetch_s      = 1'b1;
            take_redirect_s = redirect_valid;
            advance_s       = ~redirect_valid & ~id_stall;
            halt_hit_s      = ~redirect_valid & ~id_stall & req_vld_r
                              & (imem_rdata[31:26] == HALT_OPCODE);
        end else begin
            in_fetch_s = 1'b0;
        end
    end

    assign imem_en   = in_fetch_s & ~id_stall & ~redirect_valid;
    assign imem_addr = pc_r;

    // Next-state logic: HALTED is only left through reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH: begin
                if (halt_hit_s) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = FETCH;
                end
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC and the outstanding-request tracker for the word the memory is returning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            req_pc_r  <= 32'h0000_0000;
            req_vld_r <= 1'b0;
        end else if (take_redirect_s) begin
            pc_r      <= {redirect_pc[31:2], 2'b00};
            req_vld_r <= 1'b0;
        end else if (advance_s) begin
            pc_r      <= pc_r + 32'd4;
            req_pc_r  <= pc_r;
            // The word fetched behind a HALT is squashed.
            req_vld_r <= ~halt_hit_s;
        end else begin
            pc_r      <= pc_r;
            req_pc_r  <= req_pc_r;
            req_vld_r <= req_vld_r;
        end
    end

    // IF/ID output register and delivered-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid    <= 1'b0;
            if_instr    <= 32'h0000_0000;
            if_pc       <= 32'h0000_0000;
            if_pc_plus4 <= 32'h0000_0000;
            halted      <= 1'b0;
            instr_count <= 32'h0000_0000;
        end else if (take_redirect_s) begin
            if_valid <= 1'b0;
        end else if (advance_s) begin
            if_valid    <= req_vld_r;
            if_instr    <= imem_rdata;
            if_pc       <= req_pc_r;
            if_pc_plus4 <= req_pc_r + 32'd4;
            instr_count <= instr_count + {31'd0, req_vld_r};
            if (halt_hit_s) begin
                halted <= 1'b1;
            end else begin
                halted <= halted;
            end
        end else if (!in_fetch_s && !id_stall) begin
            // Halted: the HALT word is presented until ID accepts it, then bubbles forever.
            if_valid <= 1'b0;
        end else begin
            if_valid <= if_valid;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table for fetch/stall/redirect,
// plus hand sequences for HALT, asynchronous reset and PC wraparound.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        halted;
    logic [31:0] instr_count;

    logic        hi_stall = 1'b0;
    logic        hi_redirect = 1'b0;
    logic [31:0] hi_redirect_pc = 32'h0;
    logic        hi_en;
    logic [31:0] hi_addr;
    logic [31:0] hi_rdata = 32'h0;
    logic        hi_valid;
    logic [31:0] hi_instr;
    logic [31:0] hi_pc;
    logic [31:0] hi_pc_plus4;
    logic        hi_halted;
    logic [31:0] hi_count;

    logic [31:0] mem [0:63];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .id_stall(id_stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .halted(halted), .instr_count(instr_count)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .rst(rst), .id_stall(hi_stall), .redirect_valid(hi_redirect),
        .redirect_pc(hi_redirect_pc), .imem_en(hi_en), .imem_addr(hi_addr),
        .imem_rdata(hi_rdata), .if_valid(hi_valid), .if_instr(hi_instr), .if_pc(hi_pc),
        .if_pc_plus4(hi_pc_plus4), .halted(hi_halted), .instr_count(hi_count)
    );

    // Synchronous instruction memories; read data holds while the enable is low.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr[7:2]];
        if (hi_en)   hi_rdata   <= mem[hi_addr[7:2]];
    end

    function automatic logic [31:0] mword(input int i);
        return 32'h2000_0000 + i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] count;
    } vec_t;

    vec_t vecs [16];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = mword(i);

        vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,     32'h00, 32'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, mword(0),  32'h00, 32'd1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, mword(1),  32'h04, 32'd2};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, mword(1),  32'h04, 32'd2};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, mword(1),  32'h04, 32'd2};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, mword(1),  32'h04, 32'd2};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, mword(2),  32'h08, 32'd3};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, mword(3),  32'h0C, 32'd4};
        vecs[8]  = '{1'b0, 1'b1, 32'h43, 1'b0, mword(3),  32'h0C, 32'd4};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, mword(4),  32'h10, 32'd4};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b1, mword(16), 32'h40, 32'd5};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, mword(17), 32'h44, 32'd6};
        vecs[12] = '{1'b1, 1'b1, 32'h80, 1'b0, mword(17), 32'h44, 32'd6};
        vecs[13] = '{1'b1, 1'b0, 32'h0,  1'b0, mword(17), 32'h44, 32'd6};
        vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b0, mword(18), 32'h48, 32'd6};
        vecs[15] = '{1'b0, 1'b0, 32'h0,  1'b1, mword(32), 32'h80, 32'd7};

        #2;
        chk("reset if_valid", {31'd0, if_valid}, 32'd0);
        chk("reset if_pc", if_pc, 32'h0);
        chk("reset count", instr_count, 32'd0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset imem_en", {31'd0, imem_en}, 32'd1);
        rst = 1'b0;

        // Fetch, stall, redirect and redirect-with-stall table.
        for (int i = 0; i < 16; i++) begin
            id_stall       = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            tick();
            chk($sformatf("v%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d if_instr", i), if_instr, vecs[i].instr);
            chk($sformatf("v%0d if_pc", i), if_pc, vecs[i].pc);
            chk($sformatf("v%0d if_pc_plus4", i), if_pc_plus4, vecs[i].pc + 32'd4);
            chk($sformatf("v%0d count", i), instr_count, vecs[i].count);
            chk($sformatf("v%0d halted", i), {31'd0, halted}, 32'd0);
            chk($sformatf("v%0d imem_en", i), {31'd0, imem_en},
                {31'd0, ~(vecs[i].stall | vecs[i].redir)});
        end
        id_stall = 1'b0;
        redirect_valid = 1'b0;

        // HALT at address 0xC after a reset.
        mem[3] = 32'hFC00_0000;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("halt if_valid", {31'd0, if_valid}, 32'd1);
        chk("halt if_instr", if_instr, 32'hFC00_0000);
        chk("halt if_pc", if_pc, 32'h0C);
        chk("halt halted", {31'd0, halted}, 32'd1);
        chk("halt count", instr_count, 32'd4);
        chk("halt imem_en", {31'd0, imem_en}, 32'd0);
        id_stall = 1'b1;
        tick();
        chk("halt stalled valid", {31'd0, if_valid}, 32'd1);
        id_stall = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        chk("halt imem_en redirect", {31'd0, imem_en}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("halted %0d valid", i), {31'd0, if_valid}, 32'd0);
            chk($sformatf("halted %0d flag", i), {31'd0, halted}, 32'd1);
            chk($sformatf("halted %0d if_pc", i), if_pc, 32'h0C);
            chk($sformatf("halted %0d count", i), instr_count, 32'd4);
        end
        redirect_valid = 1'b0;

        // Asynchronous reset out of HALTED, then restart at RESET_PC.
        rst = 1'b1;
        #1;
        chk("rst halted", {31'd0, halted}, 32'd0);
        chk("rst count", instr_count, 32'd0);
        chk("rst imem_addr", imem_addr, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        chk("restart valid", {31'd0, if_valid}, 32'd1);
        chk("restart instr", if_instr, mword(0));
        chk("restart pc", if_pc, 32'h0);
        tick();
        chk("restart pc2", if_pc, 32'h4);
        id_stall = 1'b1;
        tick();
        chk("stall pc", if_pc, 32'h4);

        // Reset pulse while stalled clears outputs before the next edge.
        rst = 1'b1;
        #1;
        chk("midstall rst valid", {31'd0, if_valid}, 32'd0);
        chk("midstall rst if_pc", if_pc, 32'h0);
        chk("midstall rst if_instr", if_instr, 32'h0);
        chk("midstall rst pc4", if_pc_plus4, 32'h0);
        chk("midstall rst count", instr_count, 32'd0);
        id_stall = 1'b0;
        rst = 1'b0;

        // PC wraparound from RESET_PC = FFFF_FFF8.
        tick();
        chk("hi e0 valid", {31'd0, hi_valid}, 32'd0);
        tick();
        chk("hi e1 pc", hi_pc, 32'hFFFF_FFF8);
        chk("hi e1 pc4", hi_pc_plus4, 32'hFFFF_FFFC);
        chk("hi e1 instr", hi_instr, mword(62));
        tick();
        chk("hi e2 pc", hi_pc, 32'hFFFF_FFFC);
        chk("hi e2 pc4", hi_pc_plus4, 32'h0000_0000);
        chk("hi e2 instr", hi_instr, mword(63));
        tick();
        chk("hi e3 pc", hi_pc, 32'h0000_0000);
        chk("hi e3 pc4", hi_pc_plus4, 32'h0000_0004);
        chk("hi e3 instr", hi_instr, mword(0));
        chk("hi e3 count", hi_count, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
